// File: rtl/e203_exu_wbck_arbn_pkg.sv
// Shared write-back definitions: datapath widths and arbitration mode encodings.
package e203_exu_wbck_arbn_pkg;

   localparam int unsigned E203_XLEN    = 32;
   localparam int unsigned E203_RFIDX_W = 5;

   // Fairness counter width; covers a STARVE_MAX threshold up to 255
   localparam int unsigned STARVE_W = 8;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

endpackage

// File: rtl/e203_exu_wbck_arbn_sel.sv
// Combinational grant selection: lowest-index valid, or first valid after rr_ptr.
module e203_exu_wbck_arb_sel #(
   parameter int unsigned N_SRC = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [N_SRC-1:0] valid,
   input  logic [PTR_W-1:0] rr_ptr,
   input  logic             use_rr,
   output logic [N_SRC-1:0] grant
);

   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      if (use_rr) begin
         // Scan positions rr_ptr+1 .. rr_ptr+N_SRC, wrapping at N_SRC
         for (int unsigned k = 1; k <= N_SRC; k++) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
               if (!found && valid[i] && (((32'(rr_ptr) + k) % N_SRC) == i)) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
      end else begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!found && valid[i]) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/e203_exu_wbck_arbn.sv
// N-source write-back arbiter feeding the regfile write port through one output stage.
module e203_exu_wbck_arbn
   import e203_exu_wbck_arbn_pkg::*;
#(
   parameter int unsigned N_SRC      = 2,
   parameter int unsigned XLEN       = E203_XLEN,
   parameter int unsigned RFIDX_W    = E203_RFIDX_W,
   parameter int unsigned ARB_MODE   = 0,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC-1:0]         src_valid,
   output logic [N_SRC-1:0]         src_ready,
   input  logic [N_SRC*XLEN-1:0]    src_wdat,
   input  logic [N_SRC*RFIDX_W-1:0] src_rdidx,
   input  logic [N_SRC-1:0]         src_rdfpu,
   output logic                     rf_wbck_o_ena,
   output logic [XLEN-1:0]          rf_wbck_o_wdat,
   output logic [RFIDX_W-1:0]       rf_wbck_o_rdidx,
   input  logic                     rf_wbck_o_ready
);

   localparam int unsigned          PTR_W      = $clog2(N_SRC);
   localparam logic [PTR_W-1:0]     PTR_RST    = PTR_W'(N_SRC - 1);
   localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam bit                   IS_RR      = (ARB_MODE == 32'(ARB_RR));

   logic                  out_vld;
   logic [XLEN-1:0]       out_wdat;
   logic [RFIDX_W-1:0]    out_rdidx;
   logic [PTR_W-1:0]      rr_ptr;
   logic [STARVE_W-1:0]   starve_cnt;

   logic                  space_c;
   logic                  use_rr_c;
   logic                  acc_c;
   logic                  load_c;
   logic                  contest_c;
   logic [N_SRC-1:0]      grant_c;
   logic [PTR_W-1:0]      gnt_idx_c;
   logic [XLEN-1:0]       sel_wdat_c;
   logic [RFIDX_W-1:0]    sel_rdidx_c;
   logic                  sel_fpu_c;

   // Stage is free when empty or draining this cycle
   assign space_c  = ~out_vld | rf_wbck_o_ready;
   assign use_rr_c = IS_RR | (starve_cnt == STARVE_LIM);

   e203_exu_wbck_arb_sel #(
      .N_SRC (N_SRC),
      .PTR_W (PTR_W)
   ) u_arb_sel (
      .valid  (src_valid),
      .rr_ptr (rr_ptr),
      .use_rr (use_rr_c),
      .grant  (grant_c)
   );

   assign src_ready = grant_c & {N_SRC{space_c}};
   assign acc_c     = |(src_valid & src_ready);
   assign contest_c = |(src_valid & ~grant_c);

   // One-hot grant to index and payload mux
   always_comb begin
      gnt_idx_c   = '0;
      sel_wdat_c  = '0;
      sel_rdidx_c = '0;
      sel_fpu_c   = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (grant_c[i]) begin
            gnt_idx_c   = gnt_idx_c | PTR_W'(i);
            sel_wdat_c  = sel_wdat_c | src_wdat[i*XLEN +: XLEN];
            sel_rdidx_c = sel_rdidx_c | src_rdidx[i*RFIDX_W +: RFIDX_W];
            sel_fpu_c   = sel_fpu_c | src_rdfpu[i];
         end
      end
   end

   // FPU-destined entries are consumed without occupying the regfile stage
   assign load_c = acc_c & ~sel_fpu_c;

   // Output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld   <= 1'b0;
         out_wdat  <= '0;
         out_rdidx <= '0;
      end else if (load_c) begin
         out_vld   <= 1'b1;
         out_wdat  <= sel_wdat_c;
         out_rdidx <= sel_rdidx_c;
      end else if (space_c) begin
         out_vld   <= 1'b0;
      end
   end

   // Round-robin pointer tracks the last accepted source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= PTR_RST;
      end else if (acc_c) begin
         rr_ptr <= gnt_idx_c;
      end
   end

   // Starvation counter: only meaningful under fixed priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (acc_c && !IS_RR) begin
         if (use_rr_c || !contest_c) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
         end
      end
   end

   assign rf_wbck_o_ena   = out_vld;
   assign rf_wbck_o_wdat  = out_wdat;
   assign rf_wbck_o_rdidx = out_rdidx;

endmodule

// File: tb/tb_e203_exu_wbck_arbn.sv
// Scoreboard bench: a fixed-priority 2-source arbiter and a round-robin 4-source arbiter.
module tb_e203_exu_wbck_arbn;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: fixed priority, 2 sources
   logic [1:0]  va, ra, fa;
   logic [63:0] wa;
   logic [9:0]  ia;
   logic        ena_a, rdy_a;
   logic [31:0] wd_a;
   logic [4:0]  ix_a;

   // Instance B: round-robin, 4 sources
   logic [3:0]   vb, rb, fb;
   logic [127:0] wb;
   logic [19:0]  ib;
   logic         ena_b, rdy_b;
   logic [31:0]  wd_b;
   logic [4:0]   ix_b;

   e203_exu_wbck_arbn #(.N_SRC(2), .XLEN(32), .RFIDX_W(5), .ARB_MODE(0), .STARVE_MAX(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .src_valid(va), .src_ready(ra), .src_wdat(wa),
      .src_rdidx(ia), .src_rdfpu(fa), .rf_wbck_o_ena(ena_a), .rf_wbck_o_wdat(wd_a),
      .rf_wbck_o_rdidx(ix_a), .rf_wbck_o_ready(rdy_a));

   e203_exu_wbck_arbn #(.N_SRC(4), .XLEN(32), .RFIDX_W(5), .ARB_MODE(1), .STARVE_MAX(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .src_valid(vb), .src_ready(rb), .src_wdat(wb),
      .src_rdidx(ib), .src_rdfpu(fb), .rf_wbck_o_ena(ena_b), .rf_wbck_o_wdat(wd_b),
      .rf_wbck_o_rdidx(ix_b), .rf_wbck_o_ready(rdy_b));

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  i;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         // Monitor: every completed regfile write is matched against the scoreboard
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (ena_a && rdy_a) begin
                  if (qa.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL wr_a: unexpected write %h idx %0d, expected none", wd_a, ix_a);
                  end else begin
                     ea = qa.pop_front();
                     chk("wr_a_dat", 64'(wd_a), 64'(ea.d));
                     chk("wr_a_idx", 64'(ix_a), 64'(ea.i));
                  end
               end
               if (ena_b && rdy_b) begin
                  if (qb.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL wr_b: unexpected write %h idx %0d, expected none", wd_b, ix_b);
                  end else begin
                     eb = qb.pop_front();
                     chk("wr_b_dat", 64'(wd_b), 64'(eb.d));
                     chk("wr_b_idx", 64'(ix_b), 64'(eb.i));
                  end
               end
            end
         end
      join_none

      va = '0; fa = '0; wa = '0; ia = '0; rdy_a = 1'b1;
      vb = '0; fb = '0; wb = '0; ib = '0; rdy_b = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ena_a", 64'(ena_a), 64'd0);
      chk("rst_ena_b", 64'(ena_b), 64'd0);
      chk("rst_wdat_a", 64'(wd_a), 64'd0);
      chk("rst_rdidx_b", 64'(ix_b), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ena_a", 64'(ena_a), 64'd0);

      // Fixed priority, both valid: src0 x8, then src1, repeating
      for (int k = 0; k < 18; k++) begin
         logic w;
         step();
         va = 2'b11;
         wa = {32'h2000_0000 | 32'(k), 32'h1000_0000 | 32'(k)};
         ia = {5'd2, 5'd1};
         w  = ((k % 9) == 8);
         qa.push_back(w ? exp_t'({32'h2000_0000 | 32'(k), 5'd2})
                        : exp_t'({32'h1000_0000 | 32'(k), 5'd1}));
         @(negedge clk);
         chk($sformatf("fix_grant_%0d", k), 64'(ra), w ? 64'd2 : 64'd1);
      end
      step();
      va = '0;
      repeat (3) step();

      // Round-robin, all four valid: 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         int w;
         step();
         vb = 4'hF;
         for (int s = 0; s < 4; s++) begin
            wb[s*32 +: 32] = 32'h3000_0000 | (32'(s) << 8) | 32'(k);
            ib[s*5 +: 5]   = 5'(s + 10);
         end
         w = k % 4;
         qb.push_back(exp_t'({32'h3000_0000 | (32'(w) << 8) | 32'(k), 5'(w + 10)}));
         @(negedge clk);
         chk($sformatf("rr_grant_%0d", k), 64'(rb), 64'(4'b0001 << w));
         if (k > 0) chk($sformatf("rr_ena_%0d", k), 64'(ena_b), 64'd1);
      end
      step();
      vb = '0;
      repeat (3) step();

      // Back-pressure: entry held stable for three stalled cycles
      va = 2'b01;
      wa = {32'h0, 32'hDEAD_BEEF};
      ia = {5'd0, 5'd5};
      qa.push_back(exp_t'({32'hDEAD_BEEF, 5'd5}));
      @(negedge clk);
      chk("stall_load_rdy", 64'(ra), 64'd1);
      step();
      va = 2'b10;
      wa = {32'h1111_2222, 32'h0};
      ia = {5'd9, 5'd0};
      rdy_a = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall_rdy_%0d", c), 64'(ra), 64'd0);
         chk($sformatf("stall_ena_%0d", c), 64'(ena_a), 64'd1);
         chk($sformatf("stall_wdat_%0d", c), 64'(wd_a), 64'hDEAD_BEEF);
         chk($sformatf("stall_idx_%0d", c), 64'(ix_a), 64'd5);
         step();
      end
      rdy_a = 1'b1;
      qa.push_back(exp_t'({32'h1111_2222, 5'd9}));
      @(negedge clk);
      chk("stall_release_rdy", 64'(ra), 64'd2);
      step();
      va = '0;
      repeat (3) step();

      // FPU destination: accepted, never written to the regfile
      va = 2'b10;
      fa = 2'b10;
      wa = {32'h0000_0077, 32'h0};
      ia = {5'd7, 5'd0};
      @(negedge clk);
      chk("fpu_rdy", 64'(ra), 64'd2);
      step();
      va = '0;
      fa = '0;
      @(negedge clk);
      chk("fpu_no_ena", 64'(ena_a), 64'd0);
      step();
      @(negedge clk);
      chk("fpu_no_ena2", 64'(ena_a), 64'd0);

      // Reset mid-operation discards the held entry and rewinds rr_ptr
      step();
      vb = 4'b0001;
      wb[31:0] = 32'hCAFE_0001;
      ib[4:0]  = 5'd3;
      @(negedge clk);
      chk("pre_rst_rdy", 64'(rb), 64'd1);
      step();
      vb = '0;
      rdy_b = 1'b0;
      @(negedge clk);
      chk("pre_rst_ena", 64'(ena_b), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_ena", 64'(ena_b), 64'd0);
      chk("rst_async_wdat", 64'(wd_b), 64'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      rdy_b = 1'b1;
      vb = 4'hF;
      for (int s = 0; s < 4; s++) begin
         wb[s*32 +: 32] = 32'h4000_0000 | 32'(s);
         ib[s*5 +: 5]   = 5'(s + 20);
      end
      qb.push_back(exp_t'({32'h4000_0000, 5'd20}));
      #1;
      chk("post_rst_grant", 64'(rb), 64'd1);
      step();
      vb = '0;
      repeat (3) step();

      @(negedge clk);
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
